hazard_scoreboard: RTL and testbench

- Parametrised hazard-detection and forwarding controller for the in-order MIPS pipeline.
- Replaces the fixed ForwardA/B/D/E and load-use stall equations with a scoreboard. The scoreboard holds in-flight writers across DEPTH post-decode stages and tracks the stage at which each result first becomes forwardable.
- Drives the stall, bubble and flush controls, plus forwarding-mux selects for both EX operands and ID (branch-compare) operands.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hz_match.sv | 40 ++++
 rtl/hazard_scoreboard.sv | 142 ++++++++++++++
 tb/tb_hazard_scoreboard.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard scoreboard.
// sb_entry_t fields are sized for the widest supported configuration.
// Narrower register indices and stage numbers are zero-extended into them.
package hazard_pkg;

  localparam int unsigned SB_REG_W    = 8;  // widest supported register index
  localparam int unsigned SB_AVAIL_W  = 3;  // holds stage indices 0..7
  localparam int unsigned FWD_REGFILE = 0;  // select: use the ID/EX register value
  localparam int unsigned AVAIL_ALU   = 1;  // ALU results are forwardable from MEM

  // One in-flight instruction. Stage 0 also records its consumer sources.
  typedef struct packed {
    logic                  v;
    logic                  wr;
    logic [SB_REG_W-1:0]   dst;
    logic [SB_AVAIL_W-1:0] avail;
    logic [SB_REG_W-1:0]   src_rs;
    logic [SB_REG_W-1:0]   src_rt;
  } sb_entry_t;

endpackage

// File: rtl/hz_match.sv
// Youngest-first producer search over the scoreboard entry vector.
// Ports:
//   entries - scoreboard, index 0 = EX (youngest)
//   regIdx  - register being read (0 never matches)
//   hit     - a live writer of regIdx exists in stages FIRST..DEPTH-1
//   stage   - stage of the youngest such writer
//   ready   - that writer's result is already forwardable at its stage
module hz_match
  import hazard_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned FIRST = 0,
  parameter int unsigned SEL_W = $clog2(DEPTH)
) (
  input  sb_entry_t [DEPTH-1:0] entries,
  input  logic [SB_REG_W-1:0]   regIdx,
  output logic                  hit,
  output logic [SEL_W-1:0]      stage,
  output logic                  ready
);

  // Source fields and, when FIRST>0, the low stages are not searched here.
  logic unusedBits;
  assign unusedBits = ^entries;

  // Scan oldest to youngest so the youngest match overwrites any older one.
  always_comb begin
    hit   = 1'b0;
    stage = '0;
    ready = 1'b0;
    for (int s = int'(DEPTH) - 1; s >= int'(FIRST); s--) begin
      if (entries[s].v && entries[s].wr && (regIdx != '0) && (entries[s].dst == regIdx)) begin
        hit   = 1'b1;
        stage = SEL_W'(s);
        ready = (entries[s].avail <= SB_AVAIL_W'(s));
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard-based hazard detection and forwarding control for the in-order pipeline.
// Tracks writers in EX..WB, derives the EX and ID forwarding selects, the load-use
// and branch-operand stall, and the IF/ID flush on a taken branch.
// Ports:
//   Clk, Rst_n                  clock, async active-low reset
//   id_*                        decoded instruction currently in ID
//   branch_taken                branch resolved taken in ID this cycle
//   stall, flush_ifid           pipeline control
//   fwd_ex_a/b, fwd_id_a/b      forwarding selects (0 = register file, s = stage s)
// Optional build macro HAZARD_PERF_CNT_EN adds saturating stall_cnt/flush_cnt outputs.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LOAD_LAT = 2,
  parameter int unsigned SEL_W    = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_branch,
  input  logic             branch_taken,
  output logic             stall,
  output logic             flush_ifid,
  output logic [SEL_W-1:0] fwd_ex_a,
  output logic [SEL_W-1:0] fwd_ex_b,
  output logic [SEL_W-1:0] fwd_id_a,
  output logic [SEL_W-1:0] fwd_id_b
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt
`endif
);

  sb_entry_t [DEPTH-1:0] sbQ;
  sb_entry_t             stage0D;
  logic                  relOk;   // low during reset and the first cycle after it
  logic [SB_REG_W-1:0]   idRs, idRt;

  logic                  exAHit, exAReady, exBHit, exBReady;
  logic                  idAHit, idAReady, idBHit, idBReady;
  logic [SEL_W-1:0]      exAStage, exBStage, idAStage, idBStage;
  logic [SB_AVAIL_W-1:0] idAAvail, idBAvail;
  logic                  hazA, hazB;

  // Sources not actually read are treated as $zero so they never match.
  assign idRs = id_use_rs ? SB_REG_W'(id_rs) : '0;
  assign idRt = id_use_rt ? SB_REG_W'(id_rt) : '0;

  // Entry entering EX next edge: the ID instruction, or a bubble.
  always_comb begin
    stage0D = '0;
    if (id_valid && !stall && !branch_taken) begin
      stage0D.v      = 1'b1;
      stage0D.wr     = id_reg_write;
      stage0D.dst    = SB_REG_W'(id_dst);
      stage0D.avail  = id_mem_read ? SB_AVAIL_W'(LOAD_LAT) : SB_AVAIL_W'(AVAIL_ALU);
      stage0D.src_rs = idRs;
      stage0D.src_rt = idRt;
    end
  end

  // Scoreboard shift register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sbQ   <= '0;
      relOk <= 1'b0;
    end else begin
      sbQ   <= {sbQ[DEPTH-2:0], stage0D};
      relOk <= 1'b1;
    end
  end

  // EX consumers look only at older stages; ID looks at the whole pipe.
  hz_match #(.DEPTH(DEPTH), .FIRST(1), .SEL_W(SEL_W)) u_match_ex_a (
    .entries(sbQ), .regIdx(sbQ[0].src_rs), .hit(exAHit), .stage(exAStage), .ready(exAReady)
  );
  hz_match #(.DEPTH(DEPTH), .FIRST(1), .SEL_W(SEL_W)) u_match_ex_b (
    .entries(sbQ), .regIdx(sbQ[0].src_rt), .hit(exBHit), .stage(exBStage), .ready(exBReady)
  );
  hz_match #(.DEPTH(DEPTH), .FIRST(0), .SEL_W(SEL_W)) u_match_id_a (
    .entries(sbQ), .regIdx(idRs), .hit(idAHit), .stage(idAStage), .ready(idAReady)
  );
  hz_match #(.DEPTH(DEPTH), .FIRST(0), .SEL_W(SEL_W)) u_match_id_b (
    .entries(sbQ), .regIdx(idRt), .hit(idBHit), .stage(idBStage), .ready(idBReady)
  );

  // Availability stage of each ID producer.
  always_comb begin
    idAAvail = '0;
    idBAvail = '0;
    for (int s = 0; s < int'(DEPTH); s++) begin
      if (idAStage == SEL_W'(s)) idAAvail = sbQ[s].avail;
      if (idBStage == SEL_W'(s)) idBAvail = sbQ[s].avail;
    end
  end

  // Selects and hazards. A non-branch consumer only needs the value one stage later.
  always_comb begin
    fwd_ex_a   = SEL_W'(FWD_REGFILE);
    fwd_ex_b   = SEL_W'(FWD_REGFILE);
    fwd_id_a   = SEL_W'(FWD_REGFILE);
    fwd_id_b   = SEL_W'(FWD_REGFILE);
    hazA       = 1'b0;
    hazB       = 1'b0;
    if (relOk) begin
      if (exAHit && exAReady) fwd_ex_a = exAStage;
      if (exBHit && exBReady) fwd_ex_b = exBStage;
      if (idAHit && idAReady) fwd_id_a = idAStage;
      if (idBHit && idBReady) fwd_id_b = idBStage;
      if (idAHit) hazA = id_branch ? !idAReady
                                   : (idAAvail > (SB_AVAIL_W'(idAStage) + SB_AVAIL_W'(1)));
      if (idBHit) hazB = id_branch ? !idBReady
                                   : (idBAvail > (SB_AVAIL_W'(idBStage) + SB_AVAIL_W'(1)));
    end
    stall      = id_valid && (hazA || hazB);
    flush_ifid = relOk && branch_taken && !stall;
  end

`ifdef HAZARD_PERF_CNT_EN
  // Saturating event counters.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))      stall_cnt <= stall_cnt + 32'd1;
      if (flush_ifid && (flush_cnt != '1)) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

  localparam int unsigned REG_W = 5;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned SEL_W = 2;

  logic             Clk;
  logic             Rst_n;
  logic             id_valid, id_use_rs, id_use_rt, id_reg_write, id_mem_read, id_branch;
  logic             branch_taken;
  logic [REG_W-1:0] id_rs, id_rt, id_dst;
  logic             stall, flush_ifid;
  logic [SEL_W-1:0] fwd_ex_a, fwd_ex_b, fwd_id_a, fwd_id_b;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]      stall_cnt, flush_cnt;
`endif

  hazard_scoreboard #(.REG_W(REG_W), .DEPTH(DEPTH), .LOAD_LAT(2), .SEL_W(SEL_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_branch(id_branch),
    .branch_taken(branch_taken), .stall(stall), .flush_ifid(flush_ifid),
    .fwd_ex_a(fwd_ex_a), .fwd_ex_b(fwd_ex_b), .fwd_id_a(fwd_id_a), .fwd_id_b(fwd_id_b)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  typedef struct {
    logic       valid, urs, urt, rw, mr, br, bt;
    logic [4:0] rs, rt, dst;
  } instr_t;

  typedef struct {
    string name;
    int    stl, fl, exA, exB, idA, idB;
  } exp_t;

  exp_t expQ[$];
  int   errors;
  int   checks;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic instr_t nop();
    instr_t i;
    i.valid = 0; i.urs = 0; i.urt = 0; i.rw = 0; i.mr = 0; i.br = 0; i.bt = 0;
    i.rs = '0; i.rt = '0; i.dst = '0;
    return i;
  endfunction

  function automatic instr_t alu(int d, int s, int t);
    instr_t i = nop();
    i.valid = 1; i.urs = 1; i.urt = 1; i.rw = 1;
    i.rs = 5'(s); i.rt = 5'(t); i.dst = 5'(d);
    return i;
  endfunction

  function automatic instr_t ld(int d);
    instr_t i = nop();
    i.valid = 1; i.rw = 1; i.mr = 1; i.dst = 5'(d);
    return i;
  endfunction

  function automatic instr_t beq(int s, int t, bit tk);
    instr_t i = nop();
    i.valid = 1; i.urs = 1; i.urt = 1; i.br = 1; i.bt = tk;
    i.rs = 5'(s); i.rt = 5'(t);
    return i;
  endfunction

  function automatic exp_t ex(string n, int st, int fl, int a, int b, int c, int d);
    exp_t e;
    e.name = n; e.stl = st; e.fl = fl; e.exA = a; e.exB = b; e.idA = c; e.idB = d;
    return e;
  endfunction

  // Drive one ID cycle just after the edge and queue what the outputs must show.
  task automatic issue(input instr_t ins, input logic rstn, input exp_t e);
    @(posedge Clk);
    #1;
    Rst_n        = rstn;
    id_valid     = ins.valid;
    id_rs        = ins.rs;
    id_rt        = ins.rt;
    id_use_rs    = ins.urs;
    id_use_rt    = ins.urt;
    id_dst       = ins.dst;
    id_reg_write = ins.rw;
    id_mem_read  = ins.mr;
    id_branch    = ins.br;
    branch_taken = ins.bt;
    expQ.push_back(e);
  endtask

  task automatic chk(input string n, input string f, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s.%s: got %0d expected %0d", n, f, act, req);
    end
  endtask

  // Monitor: compare every queued expectation mid-cycle.
  always @(negedge Clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      chk(e.name, "stall",      int'(stall),      e.stl);
      chk(e.name, "flush_ifid", int'(flush_ifid), e.fl);
      chk(e.name, "fwd_ex_a",   int'(fwd_ex_a),   e.exA);
      chk(e.name, "fwd_ex_b",   int'(fwd_ex_b),   e.exB);
      chk(e.name, "fwd_id_a",   int'(fwd_id_a),   e.idA);
      chk(e.name, "fwd_id_b",   int'(fwd_id_b),   e.idB);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0; checks = 0;
    Rst_n = 1'b0; id_valid = 0; id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0;
    id_dst = '0; id_reg_write = 0; id_mem_read = 0; id_branch = 0; branch_taken = 0;

    // Reset and release: outputs quiet even with a taken branch presented.
    issue(beq(1, 2, 1), 1'b0, ex("rst_hold",  0, 0, 0, 0, 0, 0));
    issue(beq(1, 2, 1), 1'b1, ex("rst_first", 0, 0, 0, 0, 0, 0));
    issue(beq(1, 2, 1), 1'b1, ex("br_plain",  0, 1, 0, 0, 0, 0));
    issue(nop(),        1'b1, ex("idle",      0, 0, 0, 0, 0, 0));

    // ALU -> ALU forwarding from MEM.
    issue(alu(3, 1, 2), 1'b1, ex("aa_add",   0, 0, 0, 0, 0, 0));
    issue(alu(4, 3, 5), 1'b1, ex("aa_sub",   0, 0, 0, 0, 0, 0));
    issue(nop(),        1'b1, ex("aa_ex",    0, 0, 1, 0, 0, 0));
    issue(nop(),        1'b1, ex("aa_d1",    0, 0, 0, 0, 0, 0));
    issue(nop(),        1'b1, ex("aa_d2",    0, 0, 0, 0, 0, 0));

    // Load-use: one stall cycle, then forward both operands from WB.
    issue(ld(3),        1'b1, ex("lu_lw",    0, 0, 0, 0, 0, 0));
    issue(alu(4, 3, 3), 1'b1, ex("lu_stall", 1, 0, 0, 0, 0, 0));
    issue(alu(4, 3, 3), 1'b1, ex("lu_go",    0, 0, 0, 0, 0, 0));
    issue(nop(),        1'b1, ex("lu_ex",    0, 0, 2, 2, 0, 0));
    issue(nop(),        1'b1, ex("lu_d1",    0, 0, 0, 0, 0, 0));
    issue(nop(),        1'b1, ex("lu_d2",    0, 0, 0, 0, 0, 0));

    // Branch after load: two stall cycles with taken ignored, then flush once.
    issue(ld(3),        1'b1, ex("br_lw",    0, 0, 0, 0, 0, 0));
    issue(beq(3, 0, 1), 1'b1, ex("br_st1",   1, 0, 0, 0, 0, 0));
    issue(beq(3, 0, 1), 1'b1, ex("br_st2",   1, 0, 0, 0, 0, 0));
    issue(beq(3, 0, 1), 1'b1, ex("br_go",    0, 1, 0, 0, 2, 0));
    issue(nop(),        1'b1, ex("br_d1",    0, 0, 0, 0, 0, 0));
    issue(nop(),        1'b1, ex("br_d2",    0, 0, 0, 0, 0, 0));

    // Double writer: the younger ori wins over the older add.
    issue(alu(3, 1, 2), 1'b1, ex("dw_add",   0, 0, 0, 0, 0, 0));
    issue(alu(3, 1, 0), 1'b1, ex("dw_ori",   0, 0, 0, 0, 0, 0));
    issue(alu(6, 3, 7), 1'b1, ex("dw_and",   0, 0, 0, 0, 0, 0));
    issue(nop(),        1'b1, ex("dw_ex",    0, 0, 1, 0, 0, 0));
    issue(nop(),        1'b1, ex("dw_d1",    0, 0, 0, 0, 0, 0));
    issue(nop(),        1'b1, ex("dw_d2",    0, 0, 0, 0, 0, 0));

    // $zero never stalls or forwards.
    issue(ld(0),        1'b1, ex("z_lw",     0, 0, 0, 0, 0, 0));
    issue(alu(4, 0, 0), 1'b1, ex("z_add",    0, 0, 0, 0, 0, 0));
    issue(nop(),        1'b1, ex("z_ex",     0, 0, 0, 0, 0, 0));
    issue(nop(),        1'b1, ex("z_d1",     0, 0, 0, 0, 0, 0));
    issue(nop(),        1'b1, ex("z_d2",     0, 0, 0, 0, 0, 0));

    // Reset in the middle of a stall discards the load.
    issue(ld(3),        1'b1, ex("mr_lw",    0, 0, 0, 0, 0, 0));
    issue(beq(3, 0, 0), 1'b1, ex("mr_stall", 1, 0, 0, 0, 0, 0));
    issue(beq(3, 0, 0), 1'b0, ex("mr_rst",   0, 0, 0, 0, 0, 0));
    issue(alu(4, 3, 3), 1'b1, ex("mr_rel",   0, 0, 0, 0, 0, 0));
    issue(nop(),        1'b1, ex("mr_ex",    0, 0, 0, 0, 0, 0));
    issue(nop(),        1'b1, ex("mr_d1",    0, 0, 0, 0, 0, 0));

    repeat (3) @(posedge Clk);
    if (expQ.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations pending, expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
